imem_responder: RTL

- Instruction-memory responder on the fetch-side interface. It is the memory end of the pc/instr/instr_valid protocol.
- Samples the fetch unit's pc, waits a configurable number of cycles, then returns the 32-bit instruction with a one-cycle instr_valid pulse.
- Detects pc redirects (jumps) while a request is in flight, and flags misaligned or out-of-range fetches.
- Contains an internal word-addressed instruction store, loaded through a backdoor write port.

---
 rtl/npc_pkg.sv | 13 +
 rtl/imem_array.sv | 38 +++
 rtl/imem_responder.sv | 118 +++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// Shared types and constants for the fetch-side instruction memory.
package npc_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/imem_array.sv
// Word-addressed instruction store: synchronous write, registered read.
// A read and write to the same index on one edge returns the old word.
module imem_array
  import npc_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];
  logic [31:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // Only the read register is reset; the storage itself keeps its contents.
  always_ff @(posedge clk) begin
    if (!rstn) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Memory end of the pc/instr/instr_valid fetch protocol: samples pc, waits
// LATENCY cycles, returns the word, restarting whenever pc is redirected.
module imem_responder
  import npc_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = RESET_PC,
  parameter int          AW        = 12,
  parameter int          LATENCY   = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [63:0]   pc,
  output logic [31:0]   instr,
  output logic          instr_valid,
  output logic          instr_fault,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data
);

  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $error("imem_responder: LATENCY %0d outside 0..15", LATENCY);
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("imem_responder: BASE_ADDR must be word aligned");
  end

  localparam logic [3:0]  CNT_INIT  = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  localparam logic [61:0] BASE_WORD = BASE_ADDR[63:2];

  state_e        state_q, state_d;
  logic [63:0]   req_pc_q, req_pc_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          fault_q, fault_d;
  logic          capture;
  logic [63:0]   cap_pc;
  logic [61:0]   word_off;
  logic          cap_fault;
  logic [AW-1:0] cap_idx;
  logic [31:0]   rd_data;

  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    cap_pc   = req_pc_q;
    case (state_q)
      REQ: begin
        req_pc_d = pc;
        cap_pc   = pc;
        if (LATENCY == 0) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A redirect outranks an expiring count: the stale request never returns.
        if (pc != req_pc_q) begin
          req_pc_d = pc;
          cnt_d    = CNT_INIT;
        end else if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = REQ;
      default: state_d = REQ;
    endcase
  end

  // BASE_ADDR is word aligned, so the word offset needs no borrow from bits [1:0].
  always_comb begin
    word_off  = cap_pc[63:2] - BASE_WORD;
    cap_fault = (cap_pc[1:0] != 2'b00) || (word_off[61:AW] != '0);
    cap_idx   = word_off[AW-1:0];
  end

  always_comb begin
    fault_d = fault_q;
    if (capture) fault_d = cap_fault;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= REQ;
      req_pc_q <= '0;
      cnt_q    <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
    end
  end

  imem_array #(.AW(AW)) u_array (
    .clk   (clk),
    .rstn  (rstn),
    .we    (ld_en),
    .waddr (ld_addr),
    .wdata (ld_data),
    .re    (capture && !cap_fault),
    .raddr (cap_idx),
    .rdata (rd_data)
  );

  assign instr       = fault_q ? NOP_INSTR : rd_data;
  assign instr_fault = fault_q;
  assign instr_valid = (state_q == RESP) && (pc == req_pc_q);

endmodule
